// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_ctrl
//  Purpose  : Hazard and forwarding controller for a 5-stage MIPS pipeline.
//             Keeps a shadow scoreboard of the EXE/MEM/WB slots, decodes
//             operand forwarding selects from registered state, generates
//             load-use freeze/bubble, branch flush, multi-cycle data-memory
//             stall, and a saturating stall-cycle counter.
//  Options  : define FORWARDING_EN to build the forwarding network; without
//             it all selects are 0 and every RAW hazard against EXE/MEM
//             stalls the ID instruction instead.
//  Revision : 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_src1,
    input  logic [REG_AW-1:0] id_src2,
    input  logic [REG_AW-1:0] id_dest,
    input  logic              id_two_src,
    input  logic              id_st,
    input  logic              id_wb_en,
    input  logic              id_mem_rd,
    input  logic              br_taken,
    input  logic              mem_ready,
    output logic              freeze,
    output logic              bubble,
    output logic              flush,
    output logic              stall_all,
    output logic [1:0]        val1_sel,
    output logic [1:0]        val2_sel,
    output logic [1:0]        st_sel,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] src1;
        logic [REG_AW-1:0] src2;
        logic              two_src;
        logic              st;
        logic [REG_AW-1:0] dest;
        logic              wb_en;
        logic              mem_rd;
        logic              mem_op;
    } tag_t;

    localparam logic [1:0] c_SEL_RF  = 2'd0;
    localparam logic [1:0] c_SEL_ALU = 2'd1;
    localparam logic [1:0] c_SEL_WB  = 2'd2;
    localparam logic [1:0] c_SEL_MRD = 2'd3;

    tag_t             r_exe_tag;
    tag_t             r_mem_tag;
    tag_t             r_wb_tag;
    tag_t             w_id_tag;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_hazard;
    logic             w_unused;

    // A slot produces a register value for src when it writes a non-r0 dest equal to src
    function automatic logic dest_hit(input tag_t t, input logic [REG_AW-1:0] src);
        return t.valid && t.wb_en && (t.dest != '0) && (t.dest == src);
    endfunction

    // Pack the ID-stage decode into a scoreboard tag
    always_comb begin
        w_id_tag         = '0;
        w_id_tag.valid   = 1'b1;
        w_id_tag.src1    = id_src1;
        w_id_tag.src2    = id_src2;
        w_id_tag.two_src = id_two_src;
        w_id_tag.st      = id_st;
        w_id_tag.dest    = id_dest;
        w_id_tag.wb_en   = id_wb_en;
        w_id_tag.mem_rd  = id_mem_rd;
        w_id_tag.mem_op  = id_mem_rd | id_st;
    end

    assign stall_all = r_mem_tag.valid && r_mem_tag.mem_op && !mem_ready;
    assign flush     = br_taken;

`ifdef FORWARDING_EN
    // Only a load in EXE cannot be forwarded in time; everything else is bypassed
    assign w_hazard = r_exe_tag.valid && r_exe_tag.mem_rd && (r_exe_tag.dest != '0) &&
                      ((r_exe_tag.dest == id_src1) ||
                       (id_two_src && (r_exe_tag.dest == id_src2)));

    // MEM is younger than WB, so its result wins when both write the same register
    function automatic logic [1:0] fwd_sel(input tag_t mem_t, input tag_t wb_t,
                                           input logic [REG_AW-1:0] src);
        if (dest_hit(mem_t, src))
            return mem_t.mem_rd ? c_SEL_MRD : c_SEL_ALU;
        else if (dest_hit(wb_t, src))
            return c_SEL_WB;
        else
            return c_SEL_RF;
    endfunction

    // Operand selects decoded purely from registered tags
    always_comb begin
        val1_sel = c_SEL_RF;
        val2_sel = c_SEL_RF;
        st_sel   = c_SEL_RF;
        if (r_exe_tag.valid) begin
            val1_sel = fwd_sel(r_mem_tag, r_wb_tag, r_exe_tag.src1);
            if (r_exe_tag.two_src)
                val2_sel = fwd_sel(r_mem_tag, r_wb_tag, r_exe_tag.src2);
            if (r_exe_tag.st)
                st_sel = fwd_sel(r_mem_tag, r_wb_tag, r_exe_tag.src2);
        end
    end
`else
    // No bypass: wait until the producer has left MEM (register file writes before it reads)
    assign w_hazard = dest_hit(r_exe_tag, id_src1) || dest_hit(r_mem_tag, id_src1) ||
                      ((id_two_src || id_st) &&
                       (dest_hit(r_exe_tag, id_src2) || dest_hit(r_mem_tag, id_src2)));

    assign val1_sel = c_SEL_RF;
    assign val2_sel = c_SEL_RF;
    assign st_sel   = c_SEL_RF;
`endif

    // Branch flush and memory wait both take precedence over a data-hazard stall
    assign freeze = w_hazard && !br_taken && !stall_all;
    assign bubble = freeze;

    // Scoreboard shift: frozen during memory wait, bubble/flush inject an invalid tag
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_exe_tag <= '0;
            r_mem_tag <= '0;
            r_wb_tag  <= '0;
        end else if (!stall_all) begin
            r_wb_tag  <= r_mem_tag;
            r_mem_tag <= r_exe_tag;
            r_exe_tag <= (bubble || flush) ? '0 : w_id_tag;
        end
    end

    // Saturating count of cycles lost to freeze or memory wait
    always_ff @(posedge clk) begin
        if (!rst)
            r_stall_cnt <= '0;
        else if ((freeze || stall_all) && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + 1'b1;
    end

    assign stall_cnt = r_stall_cnt;

    // Some tag fields are only consumed in one build option
    assign w_unused = ^{r_exe_tag, r_mem_tag, r_wb_tag};

endmodule
`default_nettype wire
